and_operand_sequencer: RTL and testbench
========================================

Name: and_operand_sequencer

Overview:
- Stage that sits directly upstream and downstream of the team's 8-bit bitwise AND stage.
- Accepts a byte stream through a valid/ready handshake. Bytes pair up as operand A, then operand B.
- Holds both operands stable on op_a/op_b, which drive the AND stage's input1/input2.
- Captures the AND stage's output o on and_result and presents it downstream through a valid/ready handshake, together with a running pair count.

Parameters:
- WIDTH, 8, operand/result width in bits; must match the AND stage width.
- CNT_W, 8, width of pair_count; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns FSM to LOAD_A and drops any partial pair or pending result.
- in_data  input  WIDTH  operand byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sequencer can accept in_data.
- op_a  output  WIDTH  registered operand A, to AND stage input1.
- op_b  output  WIDTH  registered operand B, to AND stage input2.
- and_result  input  WIDTH  combinational result from AND stage output o.
- out_data  output  WIDTH  registered result.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- pair_count  output  CNT_W  number of results accepted downstream.

Behaviour:
- Reset (rst_n=0, asynchronous): state=LOAD_A, op_a=0, op_b=0, out_data=0, out_valid=0, pair_count=0, in_ready=1 (in_ready is a decode of state).
- Transfer rules: an input transfer happens when in_valid and in_ready are both 1 at a rising edge. An output transfer happens when out_valid and out_ready are both 1.
- LOAD_A: in_ready=1. On input transfer, op_a<=in_data and the state goes to LOAD_B.
- LOAD_B: in_ready=1. On input transfer, op_b<=in_data and the state goes to EVAL.
- EVAL: in_ready=0, for exactly one cycle. op_a/op_b are stable, and and_result is settled by the end of the cycle.
  - At the edge: out_data<=and_result, out_valid<=1, state goes to HOLD.
- HOLD: in_ready=0; out_valid=1; out_data, op_a and op_b are frozen.
  - On output transfer: out_valid<=0, pair_count<=pair_count+1 (wraps from 2^CNT_W-1 to 0), state goes to LOAD_A.
  - No back-to-back overlap: a new A is never accepted in the same cycle as an output transfer.
- Latency: A accepted at edge N, B at edge N+1, result captured at edge N+2. out_valid is high from N+2 until the output transfer. Minimum pair-to-pair period is 4 cycles.
- in_valid low in LOAD_A/LOAD_B: the FSM waits indefinitely with no state change.
- out_ready held low in HOLD: the FSM waits indefinitely with outputs stable. The AXI-style rule applies: out_valid never drops without a transfer, except on flush or reset.
- flush=1 at an edge, in any state:
  - state<=LOAD_A, out_valid<=0.
  - op_a, op_b, out_data and pair_count keep their values.
  - flush has priority over any simultaneous input or output transfer in that cycle; that transfer does not occur, and pair_count does not increment.
- Reset mid-operation (any state): all registers clear immediately; a partially loaded pair is discarded.
- Width: all data paths are WIDTH bits, with no arithmetic beyond the pair_count increment.
- No X may propagate: out_data changes only in EVAL.

Decomposition:
- Shared package `and_seq_pkg`:
  - state encoding constants ST_LOAD_A=2'd0, ST_LOAD_B=2'd1, ST_EVAL=2'd2, ST_HOLD=2'd3.
  - default WIDTH=8 and CNT_W=8 constants.
- The sequencer contains no AND logic. The top-level/bench instantiates the existing 8-bit AND stage between op_a/op_b and and_result.
- One natural sub-module, `hs_out_reg`: the output holding register with valid/ready and flush. The FSM stays in the parent.

Test Plan:
- Reset then stream: rst_n low for 2 cycles, then 8'hF0, 8'h3C with out_ready=1 -> out_data=8'h30; out_valid high exactly one cycle at edge N+2; pair_count=1.
- Backpressure: send 8'hFF, 8'hA5 with out_ready=0 for 5 cycles -> out_valid held, out_data=8'hA5 stable, in_ready=0 throughout; the transfer after out_ready=1 sets pair_count+1.
- Input gaps: in_valid toggled 1,0,0,1 with 8'h0F, 8'hFF -> the FSM waits in LOAD_B; result 8'h0F; op_a stays 8'h0F during the wait.
- Flush mid-pair: A=8'h55 accepted, flush=1 with in_valid=1, in_data=8'hAA -> state LOAD_A, no result, pair_count unchanged; the next pair 8'hAA, 8'hAA gives 8'hAA.
- Async reset in HOLD: assert rst_n=0 between edges -> out_valid, out_data and pair_count go to 0 immediately, without waiting for clk.
- Counter wrap: 256 pairs of 8'h01, 8'h01 -> every out_data=8'h01; pair_count reads 255 after 255 transfers and 0 after 256.

Source files
------------

// File: rtl/and_seq_pkg.sv
// and_seq_pkg
//   Shared definitions for the AND-stage operand sequencer: default data and
//   counter widths, and the sequencer state encoding.
package and_seq_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_LOAD_A = 2'd0,
      ST_LOAD_B = 2'd1,
      ST_EVAL   = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

endpackage

// File: rtl/hs_out_reg.sv
// hs_out_reg
//   Output holding register with a valid/ready handshake. It captures a word
//   on load, then holds it with out_valid high until downstream accepts it.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     flush           synchronous drop of any pending word (data is kept)
//     load, load_data capture request and the word to capture
//     out_ready       downstream accept
//     out_data        held word
//     out_valid       held word is valid
//     xfer            an output transfer happens at this edge
module hs_out_reg
   import and_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             xfer
);

   logic [WIDTH-1:0] data_q;
   logic             valid_q;

   // A flush cancels a transfer that would otherwise happen in the same cycle.
   assign xfer      = valid_q & out_ready & ~flush;
   assign out_data  = data_q;
   assign out_valid = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (load) begin
         data_q  <= load_data;
         valid_q <= 1'b1;
      end else if (xfer) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/and_operand_sequencer.sv
// and_operand_sequencer
//   Pairs an incoming byte stream into operands A and B, holds them stable for
//   the external AND stage, captures its result one cycle later and offers it
//   downstream with a running count of accepted results.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     flush                   synchronous abort back to LOAD_A
//     in_data/in_valid/in_ready    operand byte stream
//     op_a, op_b              held operands to the AND stage
//     and_result              AND stage output
//     out_data/out_valid/out_ready result stream
//     pair_count              results accepted downstream, wrapping
module and_operand_sequencer
   import and_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] and_result,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] pair_count
);

   state_e           state_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [CNT_W-1:0] pair_count_q;
   logic             out_xfer;

   // Only the two load states take input; EVAL and HOLD stall the stream so a
   // new A never lands in the same cycle as an output transfer.
   assign in_ready   = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign pair_count = pair_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_LOAD_A;
         op_a_q       <= '0;
         op_b_q       <= '0;
         pair_count_q <= '0;
      end else if (flush) begin
         // Operands and count are kept; only the sequence restarts.
         state_q <= ST_LOAD_A;
      end else begin
         case (state_q)
            ST_LOAD_A: if (in_valid) begin
               op_a_q  <= in_data;
               state_q <= ST_LOAD_B;
            end
            ST_LOAD_B: if (in_valid) begin
               op_b_q  <= in_data;
               state_q <= ST_EVAL;
            end
            ST_EVAL: state_q <= ST_HOLD;
            ST_HOLD: if (out_xfer) begin
               pair_count_q <= pair_count_q + CNT_W'(1);
               state_q      <= ST_LOAD_A;
            end
            default: state_q <= ST_LOAD_A;
         endcase
      end
   end

   // The AND result is sampled at the end of EVAL, when op_a/op_b have had a
   // full cycle to settle through the AND stage.
   hs_out_reg #(.WIDTH(WIDTH)) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .load      (state_q == ST_EVAL),
      .load_data (and_result),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .xfer      (out_xfer)
   );

endmodule

// File: tb/tb_and_operand_sequencer.sv
module tb_and_operand_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] op_a, op_b, and_result, out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] pair_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Stand-in for the 8-bit AND stage.
   assign and_result = op_a & op_b;

   always #5 clk = ~clk;

   and_operand_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .and_result(and_result),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .pair_count(pair_count)
   );

   // Reference: bytes collected so far in the current pair, a flag for a
   // complete pair whose result is due next edge, and the offered result.
   int         m_nbytes;
   logic       m_due;
   logic       m_rvalid;
   logic [7:0] m_a, m_b, m_res;
   int         m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_nbytes = 0; m_due = 1'b0; m_rvalid = 1'b0;
      m_a = '0; m_b = '0; m_res = '0; m_cnt = 0;
   endtask

   function automatic logic m_in_ready();
      return !m_due && !m_rvalid;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".in_ready"},  {31'b0, in_ready},  {31'b0, m_in_ready()});
      chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, m_rvalid});
      chk({tag, ".out_data"},  {24'b0, out_data},  {24'b0, m_res});
      chk({tag, ".op_a"},      {24'b0, op_a},      {24'b0, m_a});
      chk({tag, ".op_b"},      {24'b0, op_b},      {24'b0, m_b});
      chk({tag, ".count"},     {24'b0, pair_count}, m_cnt % 256);
   endtask

   // One clock: drive inputs, clock, advance the reference, compare.
   task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl,
                       input string tag);
      logic acc;
      in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
      acc = iv && m_in_ready();
      @(posedge clk);
      if (fl) begin
         m_nbytes = 0; m_due = 1'b0; m_rvalid = 1'b0;
      end else if (m_rvalid) begin
         if (ordy) begin m_rvalid = 1'b0; m_cnt++; end
      end else if (m_due) begin
         m_res = m_a & m_b; m_rvalid = 1'b1; m_due = 1'b0;
      end else if (acc) begin
         if (m_nbytes == 0) begin m_a = id; m_nbytes = 1; end
         else begin m_b = id; m_nbytes = 0; m_due = 1'b1; end
      end
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // Basic pair, result visible after the EVAL edge, one cycle of HOLD.
      step(1, 8'hF0, 1, 0, "t1_a");
      step(1, 8'h3C, 1, 0, "t1_b");
      step(0, 8'h00, 1, 0, "t1_eval");
      chk("t1_data", {24'b0, out_data}, 32'h30);
      chk("t1_vld",  {31'b0, out_valid}, 32'd1);
      step(0, 8'h00, 1, 0, "t1_xfer");
      chk("t1_vld_drop", {31'b0, out_valid}, 32'd0);
      chk("t1_cnt", {24'b0, pair_count}, 32'd1);

      // Backpressure in HOLD.
      step(1, 8'hFF, 0, 0, "t2_a");
      step(1, 8'hA5, 0, 0, "t2_b");
      for (int i = 0; i < 6; i++) begin
         step(1, 8'h11, 0, 0, "t2_hold");
         chk("t2_data", {24'b0, out_data}, 32'hA5);
         chk("t2_inrdy", {31'b0, in_ready}, 32'd0);
      end
      step(0, 8'h00, 1, 0, "t2_xfer");
      chk("t2_cnt", {24'b0, pair_count}, 32'd2);

      // Input gaps while waiting for B.
      step(1, 8'h0F, 1, 0, "t3_a");
      step(0, 8'h00, 1, 0, "t3_gap");
      step(0, 8'h00, 1, 0, "t3_gap");
      chk("t3_opa", {24'b0, op_a}, 32'h0F);
      step(1, 8'hFF, 1, 0, "t3_b");
      step(0, 8'h00, 0, 0, "t3_eval");
      chk("t3_data", {24'b0, out_data}, 32'h0F);
      step(0, 8'h00, 1, 0, "t3_xfer");

      // Flush after A, with a competing input byte.
      step(1, 8'h55, 1, 0, "t4_a");
      step(1, 8'hAA, 1, 1, "t4_flush");
      chk("t4_vld", {31'b0, out_valid}, 32'd0);
      chk("t4_cnt", {24'b0, pair_count}, 32'd3);
      step(1, 8'hAA, 1, 0, "t4_a2");
      step(1, 8'hAA, 1, 0, "t4_b2");
      step(0, 8'h00, 0, 0, "t4_eval");
      chk("t4_data", {24'b0, out_data}, 32'hAA);
      // Flush in HOLD with out_ready high: no transfer, no count.
      step(0, 8'h00, 1, 1, "t4_hflush");
      chk("t4_cnt2", {24'b0, pair_count}, 32'd3);

      // Asynchronous reset while holding a result.
      step(1, 8'hC3, 0, 0, "t5_a");
      step(1, 8'hF7, 0, 0, "t5_b");
      step(0, 8'h00, 0, 0, "t5_eval");
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_vld",  {31'b0, out_valid}, 32'd0);
      chk("t5_data", {24'b0, out_data}, 32'd0);
      chk("t5_cnt",  {24'b0, pair_count}, 32'd0);
      do_reset();

      // Counter wrap over 256 back-to-back pairs.
      for (int p = 1; p <= 256; p++) begin
         for (int s = 0; s < 4; s++) step(1, 8'h01, 1, 0, "t6");
         if (p == 255) chk("t6_cnt255", {24'b0, pair_count}, 32'd255);
         if (p == 256) chk("t6_cnt0",   {24'b0, pair_count}, 32'd0);
      end
      chk("t6_data", {24'b0, out_data}, 32'h01);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 2000; i++) begin
         step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
              ($urandom % 40) == 0, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
